dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single byte-addressed data memory between two requesters: the pipeline MEM stage (core port) and a debug/loader port used to preload and inspect memory. The memory takes a fixed multi-cycle access, so the block sequences each access and stalls the pipeline while a core access is pending or in flight. It sits between the EX/MEM register outputs and the data memory. Its core_stall output feeds the hazard unit's freeze of PC, IF/ID, ID/EX and EX/MEM.

Parameters:
ADDR_W, 32, address width (byte address, passed through unmodified)
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles; legal range 1..15
STARVE_MAX, 4, consecutive core grants allowed while dbg_req waits; legal range 1..15

Ports:
clock  in  1  clock, rising edge
reset  in  1  synchronous, active-low
core_req  in  1  MEM stage wants memory (load or store)
core_we  in  1  1 = store
core_addr  in  ADDR_W  core byte address
core_wdata  in  DATA_W  store data
core_rdata  out  DATA_W  load data, valid in core DONE cycle
core_stall  out  1  freeze pipeline
dbg_req  in  1  debug request; held until dbg_ack
dbg_we  in  1  1 = write
dbg_addr  in  ADDR_W  debug byte address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  read data, valid with dbg_ack
mem_en  out  1  access active
mem_we  out  1  write strobe, final access cycle only
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid in final access cycle

Behaviour:
- Reset: clock and reset are as already decided (reset reset, synchronous, active-low; clock clock). While reset==0 at a rising edge: state<=IDLE, owner<=CORE, lat_cnt<=0, starve_cnt<=0, all registered outputs <=0. core_stall=0 during reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise grant: core wins, unless dbg_req==1 and starve_cnt==STARVE_MAX, in which case dbg wins.
  - On grant, latch we/addr/wdata and owner; lat_cnt<=MEM_LAT-1; next state ACCESS.
- ACCESS:
  - mem_en=1 and mem_addr/mem_wdata come from the latched request.
  - mem_we=latched_we AND lat_cnt==0. A write commits exactly once, in the final cycle.
  - lat_cnt decrements each cycle. When lat_cnt==0, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE, one cycle:
  - Core owner: core_stall=0 and core_rdata is valid.
  - Dbg owner: dbg_ack=1 and dbg_rdata is valid.
  - Next state is IDLE. A new grant needs one IDLE cycle, so back-to-back accesses are spaced by MEM_LAT+2 cycles.
- core_stall (combinational) = core_req AND NOT(state==DONE AND owner==CORE). Total core stall per access is MEM_LAT+1 cycles when the request arrives in IDLE.
- Starvation counter:
  - +1 on each core grant while dbg_req==1.
  - Cleared on a dbg grant or whenever dbg_req==0.
  - Saturates at STARVE_MAX.
- Requester rules:
  - Core request fields are held stable by the stall.
  - If core_req drops mid-access (illegal), the access still completes and the response is discarded.
  - dbg must hold dbg_req and its fields until dbg_ack. Deasserting early is illegal; the access still completes.
- No alignment checking. Misaligned addresses pass through unchanged.
- Reset mid-ACCESS aborts the access. Because mem_we is only asserted in the final cycle, no partial write occurs.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - owner enum {OWN_CORE, OWN_DBG}
  - request struct {we, addr, wdata}
  - LAT_CNT_W constant = 4
- One sub-module is natural: arb_starve_counter (saturating counter, clear/inc inputs, at_max output).

Test Plan:
- Core load: mem[100..103]=FF,01,FF,00; core_req=1, we=0, addr=100 (MEM_LAT=2) -> core_stall high 3 cycles; core_rdata=0x00FF01FF in the DONE cycle; mem_we never 1.
- Debug write: dbg addr=40, wdata=0x00FF00FF -> mem_we high exactly 1 cycle (2nd ACCESS cycle) with addr=40; dbg_ack pulses 1 cycle, 3 cycles after grant; core_stall stays 0.
- Simultaneous: core and dbg requests both rise in IDLE -> core granted first; dbg granted at the next IDLE; dbg_ack follows core completion by 4 cycles.
- Starvation: core_req held high with a new request each completion while dbg_req is held (STARVE_MAX=4) -> exactly 4 core accesses, then the dbg access; core_stall stays high through the dbg access.
- Reset mid-write: core store to addr 100, reset=0 during the 1st ACCESS cycle -> mem_we never asserted, all outputs 0 next cycle, state IDLE; after release, a core load from addr 100 returns the old data.
- MEM_LAT=1 build: core load -> stall exactly 2 cycles; data correct.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, owner tags,
// latched request layout and counter width.
package dmem_arb_pkg;

  localparam int LAT_CNT_W  = 4;
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

  // Fields sized for the widest supported bus; narrower buses use the low bits.
  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_port_arbiter_starve.sv
// Saturating count of core grants made while a debug request is waiting.
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  logic [LAT_CNT_W-1:0] count;

  assign at_max = (count == LAT_CNT_W'(STARVE_MAX));

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + LAT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Sequences multi-cycle data-memory accesses for the MEM stage and the
// debug/loader port, stalling the pipeline while a core access is outstanding.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t               state, state_nx;
  owner_t               owner, owner_nx;
  req_t                 req_q, req_nx;
  logic [LAT_CNT_W-1:0] lat_cnt, lat_cnt_nx;
  logic                 grant_core, grant_dbg, starve_at_max, last_beat;

  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clock  (clock),
    .reset  (reset),
    .clear  (grant_dbg || !dbg_req),
    .inc    (grant_core && dbg_req),
    .at_max (starve_at_max)
  );

  assign last_beat  = (state == ACCESS) && (lat_cnt == '0);
  assign mem_en     = (state == ACCESS);
  // The write strobe is held back to the final beat so an aborted access never commits.
  assign mem_we     = last_beat && req_q.we;
  assign mem_addr   = req_q.addr[ADDR_W-1:0];
  assign mem_wdata  = req_q.wdata[DATA_W-1:0];
  assign dbg_ack    = (state == DONE) && (owner == OWN_DBG);
  assign core_stall = reset && core_req && !((state == DONE) && (owner == OWN_CORE));

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    req_nx     = req_q;
    lat_cnt_nx = lat_cnt;
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    case (state)
      IDLE: begin
        if (dbg_req && (starve_at_max || !core_req)) grant_dbg = 1'b1;
        else if (core_req)                            grant_core = 1'b1;
        if (grant_core || grant_dbg) begin
          state_nx   = ACCESS;
          lat_cnt_nx = LAT_CNT_W'(MEM_LAT - 1);
          owner_nx   = grant_dbg ? OWN_DBG : OWN_CORE;
          req_nx.we    = grant_dbg ? dbg_we : core_we;
          req_nx.addr  = grant_dbg ? REQ_ADDR_W'(dbg_addr)  : REQ_ADDR_W'(core_addr);
          req_nx.wdata = grant_dbg ? REQ_DATA_W'(dbg_wdata) : REQ_DATA_W'(core_wdata);
        end
      end
      ACCESS: begin
        if (last_beat) state_nx = DONE;
        else           lat_cnt_nx = lat_cnt - LAT_CNT_W'(1);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_CORE;
      req_q      <= '0;
      lat_cnt    <= '0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      req_q   <= req_nx;
      lat_cnt <= lat_cnt_nx;
      if (last_beat) begin
        if (owner == OWN_CORE) core_rdata <= mem_rdata;
        else                   dbg_rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a MEM_LAT=2 instance plus a MEM_LAT=1
// instance, each attached to a little-endian byte memory model.
module tb_dmem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_stall, dbg_ack, mem_en, mem_we;

  logic        l1_core_req = 0, l1_core_we = 0, l1_dbg_req = 0, l1_dbg_we = 0;
  logic [31:0] l1_core_addr = 0, l1_core_wdata = 0, l1_dbg_addr = 0, l1_dbg_wdata = 0;
  logic [31:0] l1_core_rdata, l1_dbg_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_core_stall, l1_dbg_ack, l1_mem_en, l1_mem_we;

  int checks = 0;
  int errors = 0;

  logic       preload = 0;
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1;

  assign a0 = mem_addr[7:0];
  assign a1 = l1_mem_addr[7:0];
  assign mem_rdata    = {mem[a0 + 8'd3], mem[a0 + 8'd2], mem[a0 + 8'd1], mem[a0]};
  assign l1_mem_rdata = {mem[a1 + 8'd3], mem[a1 + 8'd2], mem[a1 + 8'd1], mem[a1]};

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[100] <= 8'hFF; mem[101] <= 8'h01; mem[102] <= 8'hFF; mem[103] <= 8'h00;
    end else begin
      if (mem_we === 1'b1) begin
        mem[a0] <= mem_wdata[7:0];          mem[a0 + 8'd1] <= mem_wdata[15:8];
        mem[a0 + 8'd2] <= mem_wdata[23:16]; mem[a0 + 8'd3] <= mem_wdata[31:24];
      end
      if (l1_mem_we === 1'b1) begin
        mem[a1] <= l1_mem_wdata[7:0];          mem[a1 + 8'd1] <= l1_mem_wdata[15:8];
        mem[a1 + 8'd2] <= l1_mem_wdata[23:16]; mem[a1 + 8'd3] <= l1_mem_wdata[31:24];
      end
    end
  end

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
    .clock(clock), .reset(reset),
    .core_req(l1_core_req), .core_we(l1_core_we), .core_addr(l1_core_addr),
    .core_wdata(l1_core_wdata), .core_rdata(l1_core_rdata), .core_stall(l1_core_stall),
    .dbg_req(l1_dbg_req), .dbg_we(l1_dbg_we), .dbg_addr(l1_dbg_addr), .dbg_wdata(l1_dbg_wdata),
    .dbg_ack(l1_dbg_ack), .dbg_rdata(l1_dbg_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; preload = 1; core_req = 1; l1_core_req = 1;
    repeat (3) next_cycle();
    preload = 0;
    @(negedge clock);
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", core_stall); end
    checks++; if (l1_core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lat1: got %0b expected 0", l1_core_stall); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %0b expected 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b expected 0", mem_we); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_dbg_ack: got %0b expected 0", dbg_ack); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL reset_core_rdata: got %h expected 0", core_rdata); end
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_dbg_rdata: got %h expected 0", dbg_rdata); end
    core_req = 0; l1_core_req = 0;
    next_cycle();
    reset = 1;
    next_cycle();
  endtask

  task automatic test_core_load(input string tag);
    int stalls, wes;
    bit done;
    stalls = 0; wes = 0; done = 0;
    next_cycle();
    core_req = 1; core_we = 0; core_addr = 32'd100; core_wdata = 32'h0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clock);
      if (mem_we === 1'b1) wes++;
      if (core_stall !== 1'b0) begin
        stalls++;
        next_cycle();
      end else begin
        done = 1;
        checks++; if (core_rdata !== 32'h00FF01FF) begin errors++; $display("FAIL %s_rdata: got %h expected 00ff01ff", tag, core_rdata); end
      end
    end
    core_req = 0;
    checks++; if (!done) begin errors++; $display("FAIL %s_timeout: no DONE within 12 cycles", tag); end
    checks++; if (stalls != 3) begin errors++; $display("FAIL %s_stall_cycles: got %0d expected 3", tag, stalls); end
    checks++; if (wes != 0) begin errors++; $display("FAIL %s_mem_we: got %0d pulses expected 0", tag, wes); end
  endtask

  task automatic test_dbg_write();
    int we_n, we_cyc, ack_n, ack_cyc, stall_n;
    logic [31:0] we_addr, we_data;
    we_n = 0; we_cyc = -1; ack_n = 0; ack_cyc = -1; stall_n = 0; we_addr = 0; we_data = 0;
    next_cycle();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'd40; dbg_wdata = 32'h00FF00FF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (mem_we === 1'b1) begin we_n++; we_cyc = i; we_addr = mem_addr; we_data = mem_wdata; end
      if (dbg_ack === 1'b1) begin ack_n++; ack_cyc = i; dbg_req = 0; dbg_we = 0; end
      if (core_stall !== 1'b0) stall_n++;
      next_cycle();
    end
    dbg_req = 0;
    checks++; if (we_n != 1) begin errors++; $display("FAIL dbgw_we_count: got %0d expected 1", we_n); end
    checks++; if (we_cyc != 2) begin errors++; $display("FAIL dbgw_we_cycle: got %0d expected 2", we_cyc); end
    checks++; if (we_addr !== 32'd40) begin errors++; $display("FAIL dbgw_we_addr: got %0d expected 40", we_addr); end
    checks++; if (we_data !== 32'h00FF00FF) begin errors++; $display("FAIL dbgw_we_data: got %h expected 00ff00ff", we_data); end
    checks++; if (ack_n != 1) begin errors++; $display("FAIL dbgw_ack_count: got %0d expected 1", ack_n); end
    checks++; if (ack_cyc != 3) begin errors++; $display("FAIL dbgw_ack_cycle: got %0d expected 3", ack_cyc); end
    checks++; if (stall_n != 0) begin errors++; $display("FAIL dbgw_core_stall: got %0d cycles expected 0", stall_n); end
  endtask

  task automatic test_simultaneous();
    int core_done, ack_cyc;
    logic [31:0] first_addr, crd, drd;
    core_done = -1; ack_cyc = -1; first_addr = 0; crd = 0; drd = 0;
    next_cycle();
    core_req = 1; core_we = 0; core_addr = 32'd100;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'd40;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (i == 1) first_addr = mem_addr;
      if (core_req && core_stall === 1'b0 && core_done < 0) begin core_done = i; crd = core_rdata; core_req = 0; end
      if (dbg_ack === 1'b1 && ack_cyc < 0) begin ack_cyc = i; drd = dbg_rdata; dbg_req = 0; end
      next_cycle();
    end
    core_req = 0; dbg_req = 0;
    checks++; if (first_addr !== 32'd100) begin errors++; $display("FAIL sim_first_grant_addr: got %0d expected 100", first_addr); end
    checks++; if (core_done != 3) begin errors++; $display("FAIL sim_core_done_cycle: got %0d expected 3", core_done); end
    checks++; if (ack_cyc != 7) begin errors++; $display("FAIL sim_dbg_ack_cycle: got %0d expected 7", ack_cyc); end
    checks++; if (crd !== 32'h00FF01FF) begin errors++; $display("FAIL sim_core_rdata: got %h expected 00ff01ff", crd); end
    checks++; if (drd !== 32'h00FF00FF) begin errors++; $display("FAIL sim_dbg_rdata: got %h expected 00ff00ff", drd); end
  endtask

  task automatic test_starvation();
    int core_n, last_core, ack_cyc, hi_n;
    core_n = 0; last_core = -1; ack_cyc = -1; hi_n = 0;
    next_cycle();
    core_req = 1; core_we = 0; core_addr = 32'd100;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'd40;
    for (int i = 0; i < 40 && ack_cyc < 0; i++) begin
      @(negedge clock);
      if (core_stall !== 1'b1) begin core_n++; last_core = i; end
      if (i >= 16 && core_stall === 1'b1) hi_n++;
      if (dbg_ack === 1'b1) begin ack_cyc = i; dbg_req = 0; core_req = 0; end
      next_cycle();
    end
    core_req = 0; dbg_req = 0;
    checks++; if (core_n != 4) begin errors++; $display("FAIL starve_core_count: got %0d expected 4", core_n); end
    checks++; if (last_core != 15) begin errors++; $display("FAIL starve_last_core_done: got %0d expected 15", last_core); end
    checks++; if (ack_cyc != 19) begin errors++; $display("FAIL starve_dbg_ack_cycle: got %0d expected 19", ack_cyc); end
    checks++; if (hi_n != 4) begin errors++; $display("FAIL starve_stall_during_dbg: got %0d cycles expected 4", hi_n); end
  endtask

  task automatic test_reset_mid_write();
    int wes;
    wes = 0;
    next_cycle();
    core_req = 1; core_we = 1; core_addr = 32'd100; core_wdata = 32'hDEADBEEF;
    @(negedge clock);
    if (mem_we === 1'b1) wes++;
    next_cycle();
    @(negedge clock);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rmw_access_started: got %0b expected 1", mem_en); end
    if (mem_we === 1'b1) wes++;
    reset = 0; core_req = 0; core_we = 0; core_wdata = 32'h0;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rmw_stall_in_reset: got %0b expected 0", core_stall); end
    next_cycle();
    @(negedge clock);
    if (mem_we === 1'b1) wes++;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rmw_mem_en: got %0b expected 0", mem_en); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rmw_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rmw_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL rmw_core_rdata: got %h expected 0", core_rdata); end
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL rmw_dbg_rdata: got %h expected 0", dbg_rdata); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rmw_dbg_ack: got %0b expected 0", dbg_ack); end
    next_cycle();
    reset = 1;
    checks++; if (wes != 0) begin errors++; $display("FAIL rmw_mem_we: got %0d pulses expected 0", wes); end
    test_core_load("rmw_reload");
  endtask

  task automatic test_lat1();
    int stalls, wes;
    bit done;
    stalls = 0; wes = 0; done = 0;
    next_cycle();
    l1_core_req = 1; l1_core_we = 0; l1_core_addr = 32'd100;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clock);
      if (l1_mem_we === 1'b1) wes++;
      if (l1_core_stall !== 1'b0) begin
        stalls++;
        next_cycle();
      end else begin
        done = 1;
        checks++; if (l1_core_rdata !== 32'h00FF01FF) begin errors++; $display("FAIL lat1_rdata: got %h expected 00ff01ff", l1_core_rdata); end
      end
    end
    l1_core_req = 0;
    checks++; if (!done) begin errors++; $display("FAIL lat1_timeout: no DONE within 10 cycles"); end
    checks++; if (stalls != 2) begin errors++; $display("FAIL lat1_stall_cycles: got %0d expected 2", stalls); end
    checks++; if (wes != 0) begin errors++; $display("FAIL lat1_mem_we: got %0d pulses expected 0", wes); end
  endtask

  initial begin
    test_reset();
    test_core_load("core_load");
    test_dbg_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_write();
    test_lat1();
    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
